// File: rtl/reg_dump.sv
// ============================================================================
// Module      : reg_dump
// Description : Streams a range of register-file words out as bytes over a
//               valid/ready handshake, one debug read per word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump #(
    parameter int MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  first_addr,
    input  logic [4:0]  last_addr,
    output logic [4:0]  testaddr,
    input  logic [31:0] testreg,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [4:0]  last;
    logic [31:0] word;
    logic [1:0]  idx;
    logic [1:0]  sel;
    logic        xfer;
    logic        last_byte;

    assign xfer      = (state == ST_SEND) && byte_ready;
    assign last_byte = (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // abort wins over everything, including a simultaneous start in IDLE
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state_next = ST_LOAD;
                ST_LOAD: state_next = ST_SEND;
                ST_SEND: begin
                    if (xfer && last_byte) begin
                        state_next = (testaddr == last) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            testaddr <= 5'd0;
            last     <= 5'd0;
            word     <= 32'd0;
            idx      <= 2'd0;
        end else if (!abort) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        last     <= last_addr;
                        testaddr <= first_addr;
                    end
                end
                ST_LOAD: begin
                    word <= testreg;
                    idx  <= 2'd0;
                end
                ST_SEND: begin
                    if (xfer) begin
                        if (!last_byte) begin
                            idx <= idx + 2'd1;
                        end else if (testaddr != last) begin
                            testaddr <= testaddr + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel = (MSB_FIRST != 0) ? (2'd3 - idx) : idx;

    always_comb begin
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        if (state == ST_SEND) begin
            byte_valid = 1'b1;
            case (sel)
                2'd0:    byte_data = word[7:0];
                2'd1:    byte_data = word[15:8];
                2'd2:    byte_data = word[23:16];
                default: byte_data = word[31:24];
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_dump.sv
// ============================================================================
// Module      : tb_reg_dump
// Description : Directed self-checking bench; MSB-first and LSB-first
//               instances run side by side on shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic        byte_ready;
    logic [4:0]  ta_m, ta_l;
    logic [31:0] tr_m, tr_l;
    logic [7:0]  bd_m, bd_l;
    logic        bv_m, bv_l, busy_m, busy_l, done_m, done_l;

    logic [31:0] regfile [32];

    assign tr_m = regfile[ta_m];
    assign tr_l = regfile[ta_l];

    always #5 clk = ~clk;

    reg_dump #(.MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .testaddr(ta_m), .testreg(tr_m), .byte_data(bd_m), .byte_valid(bv_m),
        .byte_ready(byte_ready), .busy(busy_m), .done(done_m)
    );

    reg_dump #(.MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .testaddr(ta_l), .testreg(tr_l), .byte_data(bd_l), .byte_valid(bv_l),
        .byte_ready(byte_ready), .busy(busy_l), .done(done_l)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] bytes_m [$];
    logic [7:0] bytes_l [$];
    logic [4:0] addr_q  [$];
    int done_cnt, first_valid, done_at, stall_bad, stall_seen;

    function automatic logic [127:0] pack_m();
        logic [127:0] v = '0;
        foreach (bytes_m[i]) v = {v[119:0], bytes_m[i]};
        return v;
    endfunction

    function automatic logic [127:0] pack_l();
        logic [127:0] v = '0;
        foreach (bytes_l[i]) v = {v[119:0], bytes_l[i]};
        return v;
    endfunction

    function automatic logic [19:0] pack_addr();
        logic [19:0] v = '0;
        foreach (addr_q[i]) v = {v[14:0], addr_q[i]};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after an edge. mode 1 drives byte_ready 1,0,0,1 repeatedly.
    // corrupt overwrites the word being sent after its LOAD; restart re-raises
    // start with a different range while the dump is busy.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                            input int mode, input bit corrupt, input bit restart);
        logic [3:0] pat = 4'b1001;
        logic       pv, prdy;
        logic [7:0] pd, pdl;
        int         nxfer = 0;
        bytes_m.delete(); bytes_l.delete(); addr_q.delete();
        done_cnt = 0; first_valid = -1; done_at = -1; stall_bad = 0; stall_seen = 0;
        first_addr = f; last_addr = l; start = 1'b1;
        byte_ready = (mode == 1) ? pat[3] : 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            pv = bv_m; pd = bd_m; pdl = bd_l; prdy = byte_ready;
            if (bv_m && byte_ready) begin
                if (nxfer % 4 == 0) addr_q.push_back(ta_m);
                bytes_m.push_back(bd_m);
                bytes_l.push_back(bd_l);
                nxfer++;
            end
            tick();
            start = 1'b0;
            if (pv && !prdy) begin
                stall_seen++;
                if (bv_m !== 1'b1 || bd_m !== pd || bd_l !== pdl) stall_bad++;
            end
            if (bv_m && first_valid < 0) first_valid = cyc;
            if (done_m) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (corrupt && cyc == 3) regfile[ta_m] = 32'hFFFF_FFFF;
            if (restart && cyc == 4) begin
                start = 1'b1; first_addr = 5'd9; last_addr = 5'd9;
            end
            byte_ready = (mode == 1) ? pat[3 - (cyc % 4)] : 1'b1;
            if (cyc > 1 && !busy_m) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_ready = 1'b0;
        first_addr = 5'd7; last_addr = 5'd9;
        tick(); tick();
        total_cnt++; if (busy_m !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_m); else pass_cnt++;
        total_cnt++; if (bv_m !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bv_m); else pass_cnt++;
        total_cnt++; if (done_m !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_m); else pass_cnt++;
        total_cnt++; if (bd_m !== 8'h00) $display("FAIL reset_data got=%h exp=00", bd_m); else pass_cnt++;
        total_cnt++; if (ta_m !== 5'd0) $display("FAIL reset_testaddr got=%0d exp=0", ta_m); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_dump(5'd0, 5'd1, 0, 1'b0, 1'b0);
        total_cnt++; if (pack_m() !== 128'h0000_0000_0000_0001) $display("FAIL basic_msb_bytes got=%h exp=0000000000000001", pack_m()); else pass_cnt++;
        total_cnt++; if (pack_l() !== 128'h0000_0000_0100_0000) $display("FAIL basic_lsb_bytes got=%h exp=0000000001000000", pack_l()); else pass_cnt++;
        total_cnt++; if (bytes_m.size() !== 8) $display("FAIL basic_count got=%0d exp=8", bytes_m.size()); else pass_cnt++;
        total_cnt++; if (first_valid !== 2) $display("FAIL basic_first_valid got=%0d exp=2", first_valid); else pass_cnt++;
        // start sampled on edge 1, done visible after edge 11: the 12th cycle counting the start cycle
        total_cnt++; if (done_at !== 11) $display("FAIL basic_done_at got=%0d exp=11", done_at); else pass_cnt++;
        total_cnt++; if (done_cnt !== 1) $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_wrap();
        run_dump(5'd30, 5'd1, 0, 1'b0, 1'b0);
        total_cnt++; if (pack_addr() !== {5'd30, 5'd31, 5'd0, 5'd1}) $display("FAIL wrap_addrs got=%h exp=%h", pack_addr(), {5'd30, 5'd31, 5'd0, 5'd1}); else pass_cnt++;
        total_cnt++; if (bytes_m.size() !== 16) $display("FAIL wrap_count got=%0d exp=16", bytes_m.size()); else pass_cnt++;
        total_cnt++; if (pack_m() !== 128'h0000001E_0000001F_00000000_00000001) $display("FAIL wrap_bytes got=%h", pack_m()); else pass_cnt++;
        total_cnt++; if (done_cnt !== 1) $display("FAIL wrap_done_cnt got=%0d exp=1", done_cnt); else pass_cnt++;
        total_cnt++; if (done_at !== 21) $display("FAIL wrap_done_at got=%0d exp=21", done_at); else pass_cnt++;
    endtask

    task automatic test_stall();
        regfile[5] = 32'h0000_0005;
        run_dump(5'd5, 5'd5, 1, 1'b1, 1'b0);
        total_cnt++; if (pack_m() !== 128'h0000_0005) $display("FAIL stall_msb_bytes got=%h exp=00000005", pack_m()); else pass_cnt++;
        total_cnt++; if (pack_l() !== 128'h0500_0000) $display("FAIL stall_lsb_bytes got=%h exp=05000000", pack_l()); else pass_cnt++;
        total_cnt++; if (stall_bad !== 0 || stall_seen < 3) $display("FAIL stall_stable bad=%0d seen=%0d exp bad=0 seen>=3", stall_bad, stall_seen); else pass_cnt++;
        total_cnt++; if (done_cnt !== 1) $display("FAIL stall_done_cnt got=%0d exp=1", done_cnt); else pass_cnt++;
        regfile[5] = 32'h0000_0005;
    endtask

    task automatic test_abort();
        byte_ready = 1'b1; first_addr = 5'd3; last_addr = 5'd4; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        total_cnt++; if (bv_m !== 1'b1 || bd_m !== 8'h00) $display("FAIL abort_second_byte got valid=%b data=%h exp 1/00", bv_m, bd_m); else pass_cnt++;
        abort = 1'b1;
        tick(); abort = 1'b0;
        total_cnt++; if (busy_m !== 1'b0 || bv_m !== 1'b0 || done_m !== 1'b0) $display("FAIL abort_idle got busy=%b valid=%b done=%b exp 0/0/0", busy_m, bv_m, done_m); else pass_cnt++;
        tick();
        total_cnt++; if (done_m !== 1'b0 || busy_m !== 1'b0) $display("FAIL abort_no_done got done=%b busy=%b exp 0/0", done_m, busy_m); else pass_cnt++;
        abort = 1'b1; start = 1'b1;
        tick(); abort = 1'b0; start = 1'b0;
        total_cnt++; if (busy_m !== 1'b0) $display("FAIL abort_start_idle got busy=%b exp=0", busy_m); else pass_cnt++;
        run_dump(5'd3, 5'd3, 0, 1'b0, 1'b0);
        total_cnt++; if (pack_m() !== 128'h0000_0003 || bytes_m.size() !== 4) $display("FAIL abort_redump got=%h n=%0d exp=00000003 n=4", pack_m(), bytes_m.size()); else pass_cnt++;
        total_cnt++; if (done_cnt !== 1 || first_valid !== 2) $display("FAIL abort_redump_timing done=%0d first=%0d exp 1/2", done_cnt, first_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        byte_ready = 1'b1; first_addr = 5'd0; last_addr = 5'd3; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        total_cnt++; if (busy_m !== 1'b0 || bv_m !== 1'b0 || done_m !== 1'b0) $display("FAIL rstmid_ctrl got busy=%b valid=%b done=%b exp 0/0/0", busy_m, bv_m, done_m); else pass_cnt++;
        total_cnt++; if (bd_m !== 8'h00 || ta_m !== 5'd0 || ta_l !== 5'd0) $display("FAIL rstmid_data got data=%h addr=%0d/%0d exp 00/0/0", bd_m, ta_m, ta_l); else pass_cnt++;
        rst_n = 1'b1;
        run_dump(5'd2, 5'd3, 0, 1'b0, 1'b1);
        total_cnt++; if (first_valid !== 2) $display("FAIL rstmid_first_valid got=%0d exp=2", first_valid); else pass_cnt++;
        total_cnt++; if (pack_addr() !== {10'd0, 5'd2, 5'd3}) $display("FAIL busy_start_addrs got=%h exp=%h", pack_addr(), {10'd0, 5'd2, 5'd3}); else pass_cnt++;
        total_cnt++; if (pack_m() !== 128'h00000002_00000003 || done_at !== 11) $display("FAIL busy_start_bytes got=%h done_at=%0d exp=0000000200000003/11", pack_m(), done_at); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regfile[i] = i;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
